// File: rtl/morse_stream_decoder.sv
// Straight-key Morse decoder: synchronise and debounce the key, time presses
// and gaps in dot units, decode each character to ASCII and queue it in a FIFO.
module morse_stream_decoder #(
  parameter int CLK_DIV          = 1000,
  parameter int DEBOUNCE_CLKS    = 16,
  parameter int DOT_MAX_UNITS    = 2,
  parameter int LETTER_GAP_UNITS = 3,
  parameter int WORD_GAP_UNITS   = 7,
  parameter int FIFO_DEPTH       = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          key_in,
  output logic [7:0]                    char_data,
  output logic                          char_valid,
  input  logic                          char_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow,
  output logic                          key_level
);

  localparam int PRESC_W  = $clog2(CLK_DIV);
  localparam int DEB_W    = $clog2(DEBOUNCE_CLKS + 1);
  localparam int UNIT_MAX = (WORD_GAP_UNITS > DOT_MAX_UNITS + 1) ? WORD_GAP_UNITS : DOT_MAX_UNITS + 1;
  localparam int UNIT_W   = $clog2(UNIT_MAX + 1);
  localparam int PTR_W    = $clog2(FIFO_DEPTH);
  localparam int CNT_W    = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, PRESS, GAP} state_t;

  state_t             state_q, state_d;
  logic               sync1_q, sync1_d, sync2_q, sync2_d;
  logic               key_level_q, key_level_d;
  logic [DEB_W-1:0]   deb_cnt_q, deb_cnt_d;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [UNIT_W-1:0]  unit_q, unit_d, unit_inc, unit_now;
  logic [4:0]         elems_q, elems_d;
  logic [2:0]         len_q, len_d;
  logic               too_long_q, too_long_d, word_pending_q, word_pending_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               overflow_q, overflow_d;
  logic [7:0]         mem_q [FIFO_DEPTH];
  logic               key_rise, key_fall, unit_tick, push, pop, push_ok, full, letter_hit;
  logic [7:0]         push_data, decoded;

  // ITU pattern lookup; elements are right-justified, oldest element in the MSB.
  function automatic logic [7:0] decode(input logic [2:0] len, input logic [4:0] e,
                                        input logic too_long);
    logic [7:0] c;
    c = 8'h3F;
    if (!too_long) begin
      case (len)
        3'd1: c = e[0] ? 8'h54 : 8'h45;
        3'd2: case (e[1:0])
          2'b00: c = 8'h49; 2'b01: c = 8'h41; 2'b10: c = 8'h4E; default: c = 8'h4D;
        endcase
        3'd3: case (e[2:0])
          3'b000: c = 8'h53; 3'b001: c = 8'h55; 3'b010: c = 8'h52; 3'b011: c = 8'h57;
          3'b100: c = 8'h44; 3'b101: c = 8'h4B; 3'b110: c = 8'h47; default: c = 8'h4F;
        endcase
        3'd4: case (e[3:0])
          4'b0000: c = 8'h48; 4'b0001: c = 8'h56; 4'b0010: c = 8'h46; 4'b0100: c = 8'h4C;
          4'b0110: c = 8'h50; 4'b0111: c = 8'h4A; 4'b1000: c = 8'h42; 4'b1001: c = 8'h58;
          4'b1010: c = 8'h43; 4'b1011: c = 8'h59; 4'b1100: c = 8'h5A; 4'b1101: c = 8'h51;
          default: c = 8'h3F;
        endcase
        3'd5: case (e)
          5'b11111: c = 8'h30; 5'b01111: c = 8'h31; 5'b00111: c = 8'h32; 5'b00011: c = 8'h33;
          5'b00001: c = 8'h34; 5'b00000: c = 8'h35; 5'b10000: c = 8'h36; 5'b11000: c = 8'h37;
          5'b11100: c = 8'h38; 5'b11110: c = 8'h39; default: c = 8'h3F;
        endcase
        default: c = 8'h3F;
      endcase
    end
    return c;
  endfunction

  assign decoded = decode(len_q, elems_q, too_long_q);

  always_comb begin
    sync1_d     = key_in;
    sync2_d     = sync1_q;
    key_level_d = key_level_q;
    deb_cnt_d   = '0;
    if (sync2_q != key_level_q) begin
      if (deb_cnt_q == DEB_W'(DEBOUNCE_CLKS - 1)) key_level_d = sync2_q;
      else                                        deb_cnt_d   = deb_cnt_q + DEB_W'(1);
    end
  end

  assign key_rise  = key_level_d & ~key_level_q;
  assign key_fall  = ~key_level_d & key_level_q;
  assign unit_tick = (presc_q == PRESC_W'(CLK_DIV - 1));
  assign presc_d   = (key_rise || key_fall || unit_tick) ? '0 : presc_q + PRESC_W'(1);
  assign unit_inc  = (unit_q == UNIT_W'(UNIT_MAX)) ? unit_q : unit_q + UNIT_W'(1);
  assign unit_now  = unit_tick ? unit_inc : unit_q;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (key_rise) state_d = PRESS;
      PRESS:   if (key_fall) state_d = GAP;
      GAP: begin
        if (key_rise)                                               state_d = PRESS;
        else if (unit_tick && unit_inc == UNIT_W'(WORD_GAP_UNITS)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign letter_hit = (state_q == GAP) && unit_tick && (len_q != 3'd0) &&
                      (unit_inc == UNIT_W'(LETTER_GAP_UNITS));

  always_comb begin
    unit_d         = unit_q;
    elems_d        = elems_q;
    len_d          = len_q;
    too_long_d     = too_long_q;
    word_pending_d = word_pending_q;
    push           = 1'b0;
    push_data      = decoded;
    case (state_q)
      IDLE: if (key_rise) unit_d = '0;
      PRESS: begin
        unit_d = unit_now;
        if (key_fall) begin
          unit_d = '0;
          if (len_q < 3'd5) begin
            elems_d = {elems_q[3:0], (unit_now > UNIT_W'(DOT_MAX_UNITS))};
            len_d   = len_q + 3'd1;
          end else begin
            too_long_d = 1'b1;
          end
        end
      end
      GAP: begin
        unit_d = unit_now;
        // A letter boundary landing on the same clock as a new press still emits the letter.
        if (letter_hit) begin
          push           = 1'b1;
          elems_d        = '0;
          len_d          = '0;
          too_long_d     = 1'b0;
          word_pending_d = 1'b1;
        end
        if (key_rise) begin
          unit_d = '0;
        end else if (unit_tick && unit_inc == UNIT_W'(WORD_GAP_UNITS) && word_pending_q) begin
          push           = 1'b1;
          push_data      = 8'h20;
          word_pending_d = 1'b0;
        end
      end
      default: ;
    endcase
  end

  assign char_valid = (count_q != '0);
  assign full       = (count_q == CNT_W'(FIFO_DEPTH));
  assign pop        = char_valid && char_ready;
  assign push_ok    = push && (!full || pop);

  always_comb begin
    wr_ptr_d   = push_ok ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d   = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    overflow_d = overflow_q | (push && full && !pop);
    case ({push_ok, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q        <= 1'b0;
      sync2_q        <= 1'b0;
      key_level_q    <= 1'b0;
      deb_cnt_q      <= '0;
      presc_q        <= '0;
      unit_q         <= '0;
      elems_q        <= '0;
      len_q          <= '0;
      too_long_q     <= 1'b0;
      word_pending_q <= 1'b0;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      overflow_q     <= 1'b0;
    end else begin
      sync1_q        <= sync1_d;
      sync2_q        <= sync2_d;
      key_level_q    <= key_level_d;
      deb_cnt_q      <= deb_cnt_d;
      presc_q        <= presc_d;
      unit_q         <= unit_d;
      elems_q        <= elems_d;
      len_q          <= len_d;
      too_long_q     <= too_long_d;
      word_pending_q <= word_pending_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      overflow_q     <= overflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data;
  end

  // Head is gated by occupancy so an empty FIFO always presents 0x00.
  assign char_data  = char_valid ? mem_q[rd_ptr_q] : 8'h00;
  assign fifo_count = count_q;
  assign overflow   = overflow_q;
  assign key_level  = key_level_q;

endmodule
